calc_entry_controller: RTL and testbench
========================================

// Module: calc_entry_controller
// PURPOSE
//  Consumer end of the keypad KeyRdy/KeyRd handshake. Takes one decoded key per press,
//  builds signed decimal operands, latches the operator, and on '=' issues one
//  {operand_a, operand_b, opcode} request to the ALU over a valid/ready handshake.
//  Sits between the keypad scanner and the arithmetic/display datapath.
// PARAMETERS
//  WIDTH   16  operand width, two's complement; magnitude limit 2^(WIDTH-1)-1 = 32767
// PORTS
//  clk             in   1      system clock, single clock domain
//  nRST            in   1      asynchronous active-low reset
//  KeyRdy          in   1      key available; held high by keypad until key released
//  KeyRd           out  1      one-cycle acknowledge pulse to keypad
//  keypad_input    in   4      digit 0-9; 4'hF = no digit
//  operator_input  in   3      001 neg, 010 add, 011 sub, 100 mul, 000 none
//  equal_input     in   1      '=' key
//  entry_value     out  WIDTH  signed operand currently being typed (display feed)
//  entry_ovf       out  1      sticky: a digit was dropped because of magnitude limit
//  op_valid        out  1      ALU request valid
//  op_ready        in   1      ALU accepts request when op_valid && op_ready
//  operand_a       out  WIDTH  first operand; stable while op_valid
//  operand_b       out  WIDTH  second operand; stable while op_valid
//  opcode          out  3      010/011/100; stable while op_valid
// BEHAVIOUR
//  Reset (async, any state): state=S_IDLE; KeyRd, op_valid, entry_ovf=0; entry_value,
//   operand_a, operand_b=0; opcode=000; internal has_op=0, sign=0, mag=0.
//  FSM (all registered outputs):
//   S_IDLE: KeyRdy=1 at posedge -> latch the three key inputs, -> S_ACK.
//   S_ACK: KeyRd=1 for exactly this cycle; latched key processed (below); -> S_WAIT_LOW.
//   S_WAIT_LOW: stay while KeyRdy=1; KeyRdy=0 -> S_ISSUE if issue pending else S_IDLE.
//   S_ISSUE: op_valid=1; op_valid&&op_ready -> op_valid=0 next cycle, clear entry and
//    has_op, -> S_IDLE. KeyRdy ignored (keypad holds it) until back in S_IDLE.
//  Key priority inside S_ACK: equal_input > operator_input!=0 > digit (keypad<=9).
//   Key with none of these ('#', F/000/0) consumed and ignored; KeyRd still pulsed.
//  Digit d: new = mag*10+d computed at WIDTH+4 bits; new<=32767 -> mag=new;
//   else mag unchanged, entry_ovf=1. Leading zeros allowed (mag stays 0).
//  Neg (001): sign toggled; mag==0 -> sign toggled but entry_value stays 0.
//  Add/sub/mul: has_op=0 -> operand_a=entry_value, opcode latched, entry cleared
//   (mag=0, sign=0, entry_ovf=0), has_op=1. has_op=1 -> opcode replaced only,
//   operand_a and entry unchanged (no chaining).
//  Equal: has_op=1 -> operand_b=entry_value, issue pending. has_op=0 -> ignored.
//  entry_value = sign ? -mag : mag, updated the cycle after S_ACK.
//  Latency: KeyRdy high in S_IDLE -> KeyRd pulse 1 cycle later; op_valid asserts
//   1 cycle after KeyRdy falls following '='.
//  Only one key consumed per KeyRdy high period; KeyRdy stuck high never re-consumed.
//  Unused opcodes 101-111 on operator_input treated as no-key.
// TESTING
//  T1 reset mid S_ISSUE (op_valid=1) -> all outputs 0 next edge, FSM S_IDLE.
//  T2 keys 1,2,3 -> entry_value=123; exactly 3 KeyRd pulses, one per KeyRdy high.
//  T3 digits 3,2,7,6,7 then 8 -> entry_value=32767, entry_ovf=1; 3,2,7,6,8 -> 3276, ovf=1.
//  T4 5,neg,add,7,equal, op_ready=0 for 4 cycles -> op_valid held with a=-5,b=7,op=010;
//   op_ready=1 -> op_valid=0 next cycle, entry_value=0.
//  T5 9,add,sub,4,equal -> opcode=011, a=9, b=4; equal with no operator -> no op_valid.
//  T6 KeyRdy held high 50 cycles -> single KeyRd pulse; '#' key -> KeyRd, no state change.

Source files
------------

// File: rtl/calc_entry_controller.sv
// calc_entry_controller: keypad-facing entry FSM that builds signed decimal operands,
// latches the operator and issues one {operand_a, operand_b, opcode} request to the ALU.
`default_nettype none

module calc_entry_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             KeyRdy,
    output logic             KeyRd,
    input  logic [3:0]       keypad_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    output logic [WIDTH-1:0] entry_value,
    output logic             entry_ovf,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [2:0]       opcode
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK      = 2'd1,
        S_WAIT_LOW = 2'd2,
        S_ISSUE    = 2'd3
    } state_t;

    localparam int         EW      = WIDTH + 4;
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_NEG  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [EW-1:0] MAG_MAX = {{5{1'b0}}, {(WIDTH-1){1'b1}}};

    state_t           state_q;
    logic             keyrd_q, op_valid_q, ovf_q, sign_q, has_op_q, pend_q;
    logic [3:0]       key_digit_q;
    logic [2:0]       key_op_q, opcode_q;
    logic             key_eq_q;
    logic [WIDTH-1:0] mag_q, entry_q, a_q, b_q;

    logic             ovf_d, sign_d, has_op_d, pend_d;
    logic [2:0]       opcode_d;
    logic [WIDTH-1:0] mag_d, entry_d, a_d, b_d;
    logic [EW-1:0]    mag_ext, mag_new;

    // mag*10 + d, computed wide enough that the overflow compare cannot wrap
    assign mag_ext = {4'b0000, mag_q};
    assign mag_new = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, key_digit_q};

    always_comb begin
        mag_d    = mag_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        has_op_d = has_op_q;
        pend_d   = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        if (key_eq_q) begin
            if (has_op_q) begin
                b_d    = entry_q;
                pend_d = 1'b1;
            end
        end else if (key_op_q != OP_NONE) begin
            if (key_op_q == OP_NEG) begin
                sign_d = ~sign_q;
            end else if (key_op_q == OP_ADD || key_op_q == OP_SUB || key_op_q == OP_MUL) begin
                if (!has_op_q) begin
                    a_d      = entry_q;
                    mag_d    = '0;
                    sign_d   = 1'b0;
                    ovf_d    = 1'b0;
                    has_op_d = 1'b1;
                end
                opcode_d = key_op_q;
            end
        end else if (key_digit_q <= 4'd9) begin
            if (mag_new <= MAG_MAX) begin
                mag_d = mag_new[WIDTH-1:0];
            end else begin
                ovf_d = 1'b1;
            end
        end
        entry_d = sign_d ? -mag_d : mag_d;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            keyrd_q     <= 1'b0;
            op_valid_q  <= 1'b0;
            ovf_q       <= 1'b0;
            sign_q      <= 1'b0;
            has_op_q    <= 1'b0;
            pend_q      <= 1'b0;
            key_digit_q <= 4'hF;
            key_op_q    <= OP_NONE;
            key_eq_q    <= 1'b0;
            opcode_q    <= OP_NONE;
            mag_q       <= '0;
            entry_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (KeyRdy) begin
                        key_digit_q <= keypad_input;
                        key_op_q    <= operator_input;
                        key_eq_q    <= equal_input;
                        keyrd_q     <= 1'b1;
                        state_q     <= S_ACK;
                    end
                end
                S_ACK: begin
                    keyrd_q  <= 1'b0;
                    mag_q    <= mag_d;
                    sign_q   <= sign_d;
                    ovf_q    <= ovf_d;
                    has_op_q <= has_op_d;
                    pend_q   <= pend_d;
                    a_q      <= a_d;
                    b_q      <= b_d;
                    opcode_q <= opcode_d;
                    entry_q  <= entry_d;
                    state_q  <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!KeyRdy) begin
                        pend_q <= 1'b0;
                        if (pend_q) begin
                            op_valid_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_ISSUE: begin
                    // keypad stays stalled here until the ALU takes the request
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        mag_q      <= '0;
                        sign_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        entry_q    <= '0;
                        has_op_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign KeyRd       = keyrd_q;
    assign op_valid    = op_valid_q;
    assign entry_value = entry_q;
    assign entry_ovf   = ovf_q;
    assign operand_a   = a_q;
    assign operand_b   = b_q;
    assign opcode      = opcode_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_controller.sv
// Directed self-checking bench for calc_entry_controller.
`default_nettype none

module tb_calc_entry_controller;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nRST = 1'b0;
    logic         KeyRdy = 1'b0;
    logic         KeyRd;
    logic [3:0]   keypad_input = 4'hF;
    logic [2:0]   operator_input = 3'b000;
    logic         equal_input = 1'b0;
    logic [W-1:0] entry_value;
    logic         entry_ovf;
    logic         op_valid;
    logic         op_ready = 1'b0;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [2:0]   opcode;

    int vectors = 0;
    int miscompares = 0;

    calc_entry_controller #(.WIDTH(W)) dut (
        .clk(clk), .nRST(nRST), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
        .keypad_input(keypad_input), .operator_input(operator_input),
        .equal_input(equal_input), .entry_value(entry_value), .entry_ovf(entry_ovf),
        .op_valid(op_valid), .op_ready(op_ready), .operand_a(operand_a),
        .operand_b(operand_b), .opcode(opcode)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
    endtask

    // one key press: KeyRdy held for 'hold' cycles, then released; counts KeyRd pulses
    task automatic press(input logic [3:0] d, input logic [2:0] op, input logic eq,
                         input int hold, output int pulses);
        pulses = 0;
        @(negedge clk);
        keypad_input = d; operator_input = op; equal_input = eq; KeyRdy = 1'b1;
        repeat (hold) begin @(negedge clk); if (KeyRd) pulses++; end
        KeyRdy = 1'b0; keypad_input = 4'hF; operator_input = 3'b000; equal_input = 1'b0;
        repeat (2) begin @(negedge clk); if (KeyRd) pulses++; end
    endtask

    task automatic test_reset();
        int p;
        do_reset();
        vectors++;
        if ({KeyRd, op_valid, entry_ovf, entry_value, operand_a, operand_b, opcode} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got kr=%b v=%b ovf=%b e=%0d a=%0d b=%0d op=%b want all 0",
                     KeyRd, op_valid, entry_ovf, entry_value, operand_a, operand_b, opcode);
        end
        // drive into S_ISSUE, then reset asynchronously mid-request
        press(4'd2, 3'b000, 1'b0, 3, p);
        press(4'hF, 3'b010, 1'b0, 3, p);
        press(4'd3, 3'b000, 1'b0, 3, p);
        press(4'hF, 3'b000, 1'b1, 3, p);
        vectors++;
        if (op_valid !== 1'b1) begin
            miscompares++; $display("FAIL issue_before_reset: op_valid=%b want 1", op_valid);
        end
        #2 nRST = 1'b0;
        #1;
        vectors++;
        if ({KeyRd, op_valid, entry_ovf, entry_value, operand_a, operand_b, opcode} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_issue: got v=%b e=%0d a=%0d b=%0d op=%b want all 0",
                     op_valid, entry_value, operand_a, operand_b, opcode);
        end
        @(negedge clk); nRST = 1'b1;
        press(4'd4, 3'b000, 1'b0, 3, p);
        vectors++;
        if (p !== 1 || entry_value !== W'(4) || op_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: pulses=%0d e=%0d v=%b want 1/4/0", p, entry_value, op_valid);
        end
    endtask

    task automatic test_digits();
        int p, total;
        do_reset();
        total = 0;
        press(4'd1, 3'b000, 1'b0, 3, p); total += p;
        press(4'd2, 3'b000, 1'b0, 3, p); total += p;
        press(4'd3, 3'b000, 1'b0, 3, p); total += p;
        vectors++;
        if (entry_value !== W'(123) || total !== 3) begin
            miscompares++;
            $display("FAIL digits_123: e=%0d pulses=%0d want 123/3", entry_value, total);
        end
    endtask

    task automatic test_overflow();
        int p;
        do_reset();
        press(4'd3, 3'b000, 1'b0, 2, p); press(4'd2, 3'b000, 1'b0, 2, p);
        press(4'd7, 3'b000, 1'b0, 2, p); press(4'd6, 3'b000, 1'b0, 2, p);
        press(4'd7, 3'b000, 1'b0, 2, p);
        vectors++;
        if (entry_value !== W'(32767) || entry_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL max_entry: e=%0d ovf=%b want 32767/0", entry_value, entry_ovf);
        end
        press(4'd8, 3'b000, 1'b0, 2, p);
        vectors++;
        if (entry_value !== W'(32767) || entry_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drop_digit: e=%0d ovf=%b want 32767/1", entry_value, entry_ovf);
        end
        do_reset();
        press(4'd3, 3'b000, 1'b0, 2, p); press(4'd2, 3'b000, 1'b0, 2, p);
        press(4'd7, 3'b000, 1'b0, 2, p); press(4'd6, 3'b000, 1'b0, 2, p);
        press(4'd8, 3'b000, 1'b0, 2, p);
        vectors++;
        if (entry_value !== W'(3276) || entry_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_32768: e=%0d ovf=%b want 3276/1", entry_value, entry_ovf);
        end
    endtask

    task automatic test_issue_backpressure();
        int p;
        do_reset();
        press(4'd5, 3'b000, 1'b0, 3, p);
        press(4'hF, 3'b001, 1'b0, 3, p);
        vectors++;
        if (entry_value !== W'(-5)) begin
            miscompares++; $display("FAIL neg_entry: e=%0d want -5", $signed(entry_value));
        end
        press(4'hF, 3'b010, 1'b0, 3, p);
        vectors++;
        if (entry_value !== '0 || operand_a !== W'(-5) || opcode !== 3'b010) begin
            miscompares++;
            $display("FAIL add_latch: e=%0d a=%0d op=%b want 0/-5/010",
                     $signed(entry_value), $signed(operand_a), opcode);
        end
        press(4'd7, 3'b000, 1'b0, 3, p);
        // '=' pressed by hand to check op_valid latency against the KeyRdy fall
        @(negedge clk); equal_input = 1'b1; KeyRdy = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (op_valid !== 1'b0) begin
            miscompares++; $display("FAIL valid_early: op_valid=%b want 0", op_valid);
        end
        KeyRdy = 1'b0; equal_input = 1'b0;
        @(negedge clk);
        vectors++;
        if (op_valid !== 1'b1) begin
            miscompares++; $display("FAIL valid_latency: op_valid=%b want 1", op_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (op_valid !== 1'b1 || operand_a !== W'(-5) || operand_b !== W'(7) || opcode !== 3'b010) begin
                miscompares++;
                $display("FAIL hold_request[%0d]: v=%b a=%0d b=%0d op=%b want 1/-5/7/010",
                         i, op_valid, $signed(operand_a), $signed(operand_b), opcode);
            end
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        vectors++;
        if (op_valid !== 1'b0 || entry_value !== '0) begin
            miscompares++;
            $display("FAIL accept: v=%b e=%0d want 0/0", op_valid, $signed(entry_value));
        end
    endtask

    task automatic test_operator_replace();
        int p;
        do_reset();
        press(4'd9, 3'b000, 1'b0, 3, p);
        press(4'hF, 3'b010, 1'b0, 3, p);
        press(4'hF, 3'b011, 1'b0, 3, p);
        press(4'd4, 3'b000, 1'b0, 3, p);
        press(4'hF, 3'b000, 1'b1, 3, p);
        vectors++;
        if (op_valid !== 1'b1 || opcode !== 3'b011 || operand_a !== W'(9) || operand_b !== W'(4)) begin
            miscompares++;
            $display("FAIL op_replace: v=%b op=%b a=%0d b=%0d want 1/011/9/4",
                     op_valid, opcode, operand_a, operand_b);
        end
        op_ready = 1'b1; @(negedge clk); op_ready = 1'b0;
        do_reset();
        press(4'd6, 3'b000, 1'b0, 3, p);
        press(4'hF, 3'b000, 1'b1, 3, p);
        vectors++;
        if (op_valid !== 1'b0 || entry_value !== W'(6)) begin
            miscompares++;
            $display("FAIL equal_no_op: v=%b e=%0d want 0/6", op_valid, entry_value);
        end
        do_reset();
        press(4'hF, 3'b001, 1'b0, 3, p);
        vectors++;
        if (entry_value !== '0) begin
            miscompares++; $display("FAIL neg_zero: e=%0d want 0", $signed(entry_value));
        end
        press(4'd0, 3'b000, 1'b0, 3, p);
        press(4'd4, 3'b000, 1'b0, 3, p);
        vectors++;
        if (entry_value !== W'(-4)) begin
            miscompares++; $display("FAIL neg_then_digit: e=%0d want -4", $signed(entry_value));
        end
    endtask

    task automatic test_stuck_and_nokey();
        int p;
        do_reset();
        press(4'd5, 3'b000, 1'b0, 50, p);
        vectors++;
        if (p !== 1 || entry_value !== W'(5)) begin
            miscompares++;
            $display("FAIL stuck_keyrdy: pulses=%0d e=%0d want 1/5", p, entry_value);
        end
        press(4'hF, 3'b000, 1'b0, 3, p);
        vectors++;
        if (p !== 1 || entry_value !== W'(5) || entry_ovf !== 1'b0 || opcode !== 3'b000) begin
            miscompares++;
            $display("FAIL hash_key: pulses=%0d e=%0d ovf=%b op=%b want 1/5/0/000",
                     p, entry_value, entry_ovf, opcode);
        end
        press(4'd3, 3'b101, 1'b0, 3, p);
        vectors++;
        if (p !== 1 || entry_value !== W'(5) || opcode !== 3'b000) begin
            miscompares++;
            $display("FAIL unused_opcode: pulses=%0d e=%0d op=%b want 1/5/000", p, entry_value, opcode);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_overflow();
        test_issue_backpressure();
        test_operator_replace();
        test_stuck_and_nokey();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
